cpu_controller: RTL

//  Instruction sequencer for the 8-bit RISC CPU (3b opcode / 5b address format).
//  It steps an 8-phase machine cycle and decodes the instruction register's opcode and the accumulator zero flag.
//  It drives every load/enable strobe, including ld_ir back into the instruction register.
//  It sits between the IR and PC/ACC/ALU/memory-mux/memory.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/ctrl_phase_cnt.sv | 22 ++
 rtl/cpu_controller.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the 8-bit RISC CPU sequencer.
//   OP_W     - opcode field width (3)
//   opcode_e - instruction opcodes HLT..JMP
//   phase_e  - the eight machine-cycle phases INST_ADDR..STORE
package cpu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

endpackage

// File: rtl/ctrl_phase_cnt.sv
// ctrl_phase_cnt: 3-bit machine-cycle phase counter, wraps 7 -> 0.
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   async active-low reset (phase -> 0)
//   hold  in   1 = keep the current phase
//   phase out  current phase
module ctrl_phase_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hold,
   output logic [2:0] phase
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 3'd0;
      end else if (!hold) begin
         phase <= phase + 3'd1;
      end
   end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction sequencer for the 8-bit RISC CPU.
// Steps an 8-phase machine cycle and decodes opcode/zero into the
// datapath load and enable strobes.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   opcode      instruction opcode from IR
//   zero        accumulator == 0
//   step        (CTRL_STEP_EN only) run one instruction from phase 0
//   sel         memory address from PC (1) or IR address field (0)
//   rd, wr      memory read enable / write strobe
//   ld_ir       load IR from memory
//   inc_pc      PC increment
//   ld_pc       PC load (jump)
//   ld_ac       accumulator load from ALU
//   data_e      drive ACC onto memory data bus
//   halt        sticky halt, cleared only by reset
// Build option: define CTRL_STEP_EN to add the single-step input.
//
// phase      | meaning
// INST_ADDR  | instruction address from PC
// INST_FETCH | instruction read
// INST_LOAD  | IR loads
// IDLE       | IR loads, read held
// OP_ADDR    | PC increment; HLT latches halt
// OP_FETCH   | operand read for ALU ops
// ALU_OP     | SKZ skip / JMP load / STO data drive
// STORE      | ACC load, JMP load, STO write
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int OP_W = cpu_pkg::OP_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
`ifdef CTRL_STEP_EN
   input  logic            step,
`endif
   output logic            sel,
   output logic            rd,
   output logic            ld_ir,
   output logic            inc_pc,
   output logic            ld_pc,
   output logic            ld_ac,
   output logic            wr,
   output logic            data_e,
   output logic            halt
);

   if (OP_W != 3) begin : g_bad_op_w
      $error("cpu_controller: OP_W must be 3");
   end

   logic [2:0] phase_cnt;
   phase_e     phase;
   logic       hold;
   logic       op_hlt, op_skz, op_alu, op_sto, op_jmp;

   assign phase = phase_e'(phase_cnt);

`ifdef CTRL_STEP_EN
   assign hold = halt | ((phase == INST_ADDR) & ~step);
`else
   assign hold = halt;
`endif

   ctrl_phase_cnt u_phase_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .hold  (hold),
      .phase (phase_cnt)
   );

   // Unlisted (or X) opcodes leave every flag low, so only the phase-4
   // inc_pc survives for them.
   always_comb begin
      op_hlt = 1'b0;
      op_skz = 1'b0;
      op_alu = 1'b0;
      op_sto = 1'b0;
      op_jmp = 1'b0;
      case (opcode)
         HLT:               op_hlt = 1'b1;
         SKZ:               op_skz = 1'b1;
         ADD, AND, XOR, LDA: op_alu = 1'b1;
         STO:               op_sto = 1'b1;
         JMP:               op_jmp = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt <= 1'b0;
      end else if ((phase == OP_ADDR) && op_hlt) begin
         halt <= 1'b1;
      end
   end

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      if (!halt) begin
         case (phase)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: inc_pc = 1'b1;
            OP_FETCH: rd = op_alu;
            ALU_OP: begin
               rd     = op_alu;
               inc_pc = op_skz & zero;
               ld_pc  = op_jmp;
               data_e = op_sto;
            end
            STORE: begin
               rd     = op_alu;
               ld_ac  = op_alu;
               ld_pc  = op_jmp;
               wr     = op_sto;
               data_e = op_sto;
            end
            default: ;
         endcase
      end
   end

endmodule
